systolic_skew_feeder: RTL and testbench
=======================================

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 The module SHALL provide parameter DEPTH, default 8: number of lanes, and the matrix dimension (DEPTH x DEPTH).
REQ-002 The module SHALL provide parameter BITS, default 8: element width in bits.
REQ-003 The module SHALL provide port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-004 The module SHALL provide port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL provide port clr, input, 1 bit: synchronous abort; discards the current matrix.
REQ-006 The module SHALL provide port in_valid, input, 1 bit: in_row holds a valid matrix row.
REQ-007 The module SHALL provide port in_ready, output, 1 bit: the feeder accepts a row this cycle.
REQ-008 The module SHALL provide port in_row, input, unpacked array [DEPTH-1:0] of BITS bits: one matrix row; element c is column c.
REQ-009 The module SHALL provide port out_stall, input, 1 bit: downstream freezes the wavefront.
REQ-010 The module SHALL provide port out_valid, output, 1 bit: out_data is a valid wavefront step.
REQ-011 The module SHALL provide port out_data, output, unpacked array [DEPTH-1:0] of BITS bits: skewed lane values.
REQ-012 The module SHALL provide port out_last, output, 1 bit: the final wavefront step of the matrix.
REQ-013 The module SHALL provide port busy, output, 1 bit: high whenever state is not LOAD or row_cnt != 0.

Function
REQ-014 The module SHALL implement two states: LOAD and DRAIN.
REQ-015 The module SHALL hold an internal buffer M[DEPTH][DEPTH], a row counter row_cnt (0..DEPTH-1) and a step counter t (0..2*DEPTH-2).
REQ-016 In LOAD, in_ready SHALL be 1; in DRAIN, in_ready SHALL be 0.
REQ-017 A row SHALL be accepted on a rising edge with in_valid=1, in_ready=1 and clr=0: M[row_cnt] <= in_row, and row_cnt increments.
REQ-018 Accepting row DEPTH-1 SHALL move the state to DRAIN with t=0 and row_cnt=0 on the same edge.
REQ-019 The first out_valid SHALL appear in the cycle immediately after the last row is accepted (latency 1 cycle).
REQ-020 out_valid SHALL be 1 exactly when the state is DRAIN.
REQ-021 In DRAIN, out_data[i] SHALL equal M[t-i][i] when 0 <= t-i <= DEPTH-1, and 0 otherwise (diagonal skew; lane i lags lane 0 by i cycles).
REQ-022 When out_valid=0, every out_data lane SHALL be 0.
REQ-023 out_last SHALL be 1 only when the state is DRAIN and t == 2*DEPTH-2.
REQ-024 In DRAIN with out_stall=0, t SHALL increment each cycle.
REQ-025 At t == 2*DEPTH-2 with out_stall=0, the next state SHALL be LOAD, with t reset to 0.
REQ-026 With out_stall=1 in DRAIN, t, M, out_data, out_valid and out_last SHALL all hold.
REQ-027 out_stall SHALL have no effect in LOAD.
REQ-028 A drain SHALL produce exactly 2*DEPTH-1 unstalled valid cycles.
REQ-029 In LOAD, in_valid=0 SHALL leave row_cnt and M unchanged; a gap between rows is legal.
REQ-030 clr=1 SHALL, on the next edge, force LOAD with row_cnt=0 and t=0, in either state.
REQ-031 clr SHALL take priority over acceptance, advance and out_stall when asserted simultaneously with them.
REQ-032 On clr, M contents need not be cleared; stale contents SHALL never appear on out_data before DEPTH new rows are accepted.
REQ-033 The module SHALL perform no arithmetic on data; elements pass bit-exact.
REQ-034 t SHALL be $clog2(2*DEPTH) bits wide.
REQ-035 row_cnt SHALL be $clog2(DEPTH) bits wide, with a minimum of 1 bit.

Reset
REQ-036 While rst_n=0, the module SHALL be in LOAD with row_cnt=0 and t=0.
REQ-037 While rst_n=0, outputs SHALL be in_ready=1, out_valid=0, out_last=0, busy=0 and all out_data lanes 0.
REQ-038 Assertion of rst_n mid-LOAD or mid-DRAIN SHALL abort immediately (asynchronously), with no further output.
REQ-039 The contents of M SHALL be don't-care after reset.

Verification (DEPTH=4, BITS=8, M[r][c]=16*r+c)
REQ-040 The bench SHALL cover basic skew: load 4 rows back-to-back -> out_valid appears the next cycle; t=0 gives {0x00,0,0,0}; t=1 gives {0x10,0x01,0,0}; t=3 gives {0x30,0x21,0x12,0x03}; t=6 gives {0,0,0,0x33} with out_last=1; the next cycle gives in_ready=1, out_valid=0.
REQ-041 The bench SHALL cover stall: out_stall=1 for 3 cycles at t=2 -> out_data is held at {0x20,0x11,0x02,0} for 4 cycles total, and the drain completes after 10 valid cycles.
REQ-042 The bench SHALL cover input gaps: in_valid toggling 1,0,1,0,... -> exactly 4 rows are captured, and the output is identical to REQ-040.
REQ-043 The bench SHALL cover clr mid-drain: clr at t=4 -> the next cycle gives out_valid=0, in_ready=1, busy=0; a new matrix of all 0xAA is then loaded, and t=0 gives {0xAA,0,0,0}.
REQ-044 The bench SHALL cover clr with simultaneous in_valid on row 2: the row is not captured and row_cnt=0; 4 fresh rows are then required before out_valid.
REQ-045 The bench SHALL cover async reset mid-drain: rst_n low at t=3 -> out_valid and out_data are 0 immediately, and in_ready=1 after release.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// ============================================================================
// Module   : systolic_skew_feeder
// Brief    : Buffers a DEPTH x DEPTH matrix row by row, then replays it as a
//            diagonally skewed wavefront (lane i lags lane 0 by i cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_skew_feeder #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_row   [DEPTH-1:0],
  input  logic            out_stall,
  output logic            out_valid,
  output logic [BITS-1:0] out_data [DEPTH-1:0],
  output logic            out_last,
  output logic            busy
);

  localparam int TW = $clog2(2 * DEPTH);
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(2 * DEPTH - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [TW-1:0]   t_q, t_d;
  logic [BITS-1:0] m_q [DEPTH][DEPTH];
  logic [BITS-1:0] m_d [DEPTH][DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      row_cnt_q <= '0;
      t_q       <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      t_q       <= t_d;
    end
  end

  // Matrix storage carries no reset; it is only visible once fully reloaded.
  always_ff @(posedge clk) begin
    m_q <= m_d;
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    t_d       = t_q;
    m_d       = m_q;
    if (clr) begin
      state_d   = LOAD;
      row_cnt_d = '0;
      t_d       = '0;
    end else if (state_q == LOAD) begin
      if (in_valid) begin
        for (int c = 0; c < DEPTH; c++) begin
          m_d[row_cnt_q][c] = in_row[c];
        end
        if (row_cnt_q == ROW_LAST) begin
          state_d   = DRAIN;
          row_cnt_d = '0;
          t_d       = '0;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
    end else if (!out_stall) begin
      if (t_q == T_LAST) begin
        state_d = LOAD;
        t_d     = '0;
      end else begin
        t_d = t_q + 1'b1;
      end
    end
  end

  // Element M[r][c] sits on lane c at wavefront step t = r + c.
  always_comb begin
    for (int c = 0; c < DEPTH; c++) begin
      out_data[c] = '0;
    end
    if (state_q == DRAIN) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < DEPTH; c++) begin
          if (int'(t_q) == r + c) begin
            out_data[c] = m_q[r][c];
          end
        end
      end
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (t_q == T_LAST);
  assign busy      = (state_q != LOAD) || (row_cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Brief    : Directed and randomized checks of systolic_skew_feeder (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_skew_feeder;

  localparam int DEPTH = 4;
  localparam int BITS  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_row   [DEPTH-1:0];
  logic            out_stall;
  logic            out_valid;
  logic [BITS-1:0] out_data [DEPTH-1:0];
  logic            out_last;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .DEPTH(DEPTH),
    .BITS (BITS)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .out_stall(out_stall),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lane 0 in the low byte.
  function automatic logic [31:0] lanes();
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) v[8*i +: 8] = out_data[i];
    return v;
  endfunction

  function automatic logic [7:0] pat(input logic [7:0] base, input int stride, input int r, input int c);
    return base + 8'(stride * (16 * r + c));
  endfunction

  function automatic logic [31:0] wave(input logic [7:0] base, input int stride, input int t);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < DEPTH; i++)
      if (t - i >= 0 && t - i < DEPTH) w[8*i +: 8] = pat(base, stride, t - i, i);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_matrix(input logic [7:0] base, input int stride);
    for (int r = 0; r < DEPTH; r++) begin
      check("load_no_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1;
      for (int c = 0; c < DEPTH; c++) in_row[c] = pat(base, stride, r, c);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Reference model state for the randomized phase.
  bit         m_drain;
  int         m_rows;
  int         m_t;
  logic [7:0] m_mat [DEPTH][DEPTH];

  initial begin
    int          nvalid;
    logic [31:0] exp_w;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_stall = 1'b0;
    for (int c = 0; c < DEPTH; c++) in_row[c] = '0;
    tick(); tick();
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last",  {31'd0, out_last}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_data",  lanes(), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic skew
    load_matrix(8'h00, 1);
    for (int t = 0; t < 2 * DEPTH - 1; t++) begin
      check("basic_valid", {31'd0, out_valid}, 32'd1);
      check("basic_ready", {31'd0, in_ready}, 32'd0);
      check("basic_data", lanes(), wave(8'h00, 1, t));
      check("basic_last", {31'd0, out_last}, {31'd0, t == 2 * DEPTH - 2});
      if (t == 1) check("basic_t1", lanes(), 32'h0000_0110);
      if (t == 3) check("basic_t3", lanes(), 32'h0312_2130);
      if (t == 6) check("basic_t6", lanes(), 32'h3300_0000);
      tick();
    end
    check("basic_end_ready", {31'd0, in_ready}, 32'd1);
    check("basic_end_valid", {31'd0, out_valid}, 32'd0);
    check("basic_end_data", lanes(), 32'd0);

    // Stall for three cycles at t=2
    load_matrix(8'h00, 1);
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) nvalid++;
      if (k >= 2 && k <= 5) check("stall_hold", lanes(), 32'h0002_1120);
      out_stall = (k >= 2 && k <= 4);
      tick();
    end
    out_stall = 1'b0;
    check("stall_count", nvalid, 32'd10);

    // Input gaps: in_valid 1,0,1,0,...
    for (int i = 0; i < 2 * DEPTH - 1; i++) begin
      check("gap_no_valid", {31'd0, out_valid}, 32'd0);
      in_valid = (i % 2 == 0);
      for (int c = 0; c < DEPTH; c++)
        in_row[c] = in_valid ? pat(8'h00, 1, i / 2, c) : 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 2 * DEPTH - 1; t++) begin
      check("gap_valid", {31'd0, out_valid}, 32'd1);
      check("gap_data", lanes(), wave(8'h00, 1, t));
      tick();
    end
    check("gap_end_valid", {31'd0, out_valid}, 32'd0);

    // clr mid-drain at t=4
    load_matrix(8'h00, 1);
    repeat (4) tick();
    check("clrd_t4", lanes(), wave(8'h00, 1, 4));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrd_valid", {31'd0, out_valid}, 32'd0);
    check("clrd_ready", {31'd0, in_ready}, 32'd1);
    check("clrd_busy",  {31'd0, busy}, 32'd0);
    check("clrd_data",  lanes(), 32'd0);
    load_matrix(8'hAA, 0);
    check("clrd_aa_t0", lanes(), 32'h0000_00AA);
    repeat (2 * DEPTH - 1) tick();

    // clr together with in_valid on row 2
    for (int r = 0; r < 3; r++) begin
      in_valid = 1'b1;
      clr = (r == 2);
      for (int c = 0; c < DEPTH; c++) in_row[c] = pat(8'h10, 1, r, c);
      tick();
    end
    in_valid = 1'b0; clr = 1'b0;
    check("clrr_busy",  {31'd0, busy}, 32'd0);
    check("clrr_ready", {31'd0, in_ready}, 32'd1);
    load_matrix(8'h40, 1);
    check("clrr_valid", {31'd0, out_valid}, 32'd1);
    check("clrr_t0", lanes(), 32'h0000_0040);
    repeat (2 * DEPTH - 1) tick();

    // Async reset mid-drain at t=3
    load_matrix(8'h00, 1);
    repeat (3) tick();
    check("arst_t3", lanes(), 32'h0312_2130);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data",  lanes(), 32'd0);
    check("arst_last",  {31'd0, out_last}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_busy",  {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_rel_ready", {31'd0, in_ready}, 32'd1);
    check("arst_rel_valid", {31'd0, out_valid}, 32'd0);

    // Randomized traffic against the reference model
    m_drain = 1'b0; m_rows = 0; m_t = 0;
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_stall = ($urandom_range(0, 3) == 0);
      clr       = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < DEPTH; c++) in_row[c] = 8'($urandom);

      exp_w = '0;
      if (m_drain)
        for (int i = 0; i < DEPTH; i++)
          if (m_t - i >= 0 && m_t - i < DEPTH) exp_w[8*i +: 8] = m_mat[m_t - i][i];
      check("rnd_ready", {31'd0, in_ready}, {31'd0, !m_drain});
      check("rnd_valid", {31'd0, out_valid}, {31'd0, m_drain});
      check("rnd_last",  {31'd0, out_last}, {31'd0, m_drain && m_t == 2 * DEPTH - 2});
      check("rnd_busy",  {31'd0, busy}, {31'd0, m_drain || m_rows != 0});
      check("rnd_data",  lanes(), exp_w);

      if (clr) begin
        m_drain = 1'b0; m_rows = 0; m_t = 0;
      end else if (!m_drain) begin
        if (in_valid) begin
          for (int c = 0; c < DEPTH; c++) m_mat[m_rows][c] = in_row[c];
          m_rows++;
          if (m_rows == DEPTH) begin
            m_drain = 1'b1; m_rows = 0; m_t = 0;
          end
        end
      end else if (!out_stall) begin
        m_t++;
        if (m_t == 2 * DEPTH - 1) begin
          m_drain = 1'b0; m_t = 0;
        end
      end
      tick();
    end
    in_valid = 1'b0; out_stall = 1'b0; clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
